// File: rtl/fetch_unit_if.sv
// Fetch unit bus: memory port 0, redirect input and instruction handshake.
// master = fetch side, slave = memory/execute/decode side.
interface fetch_unit_if;
   logic [7:0]  MEM_ADDR;
   logic [15:0] MEM_WD;
   logic        MEM_WE;
   logic [15:0] MEM_RD;
   logic        BR_TAKEN;
   logic [7:0]  BR_TARGET;
   logic [15:0] INSTR;
   logic [7:0]  INSTR_PC;
   logic        INSTR_VALID;
   logic        INSTR_READY;

   modport master (
      output MEM_ADDR, MEM_WD, MEM_WE,
      input  MEM_RD,
      input  BR_TAKEN, BR_TARGET,
      output INSTR, INSTR_PC, INSTR_VALID,
      input  INSTR_READY
   );

   modport slave (
      input  MEM_ADDR, MEM_WD, MEM_WE,
      output MEM_RD,
      output BR_TAKEN, BR_TARGET,
      input  INSTR, INSTR_PC, INSTR_VALID,
      output INSTR_READY
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one outstanding read, 2-entry instruction buffer.
// Optional macro FETCH_STALL_CNT_EN adds a saturating STALL_CNT output.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic         CLK,
   input  logic         RST,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]  STALL_CNT,
`endif
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  pc_q;
   logic [7:0]  iss_pc_q;
   logic        inflight_q;
   logic [7:0]  ent_pc  [2];
   logic [15:0] ent_ins [2];

   logic        br;
   logic        valid;
   logic        deq;
   logic        enq;
   logic        issue;
   logic        wr_hi;
   logic [1:0]  cnt;
   logic [2:0]  occ;

   // Handshake decode, issue decision and buffer write slot
   always_comb begin
      br    = bus.BR_TAKEN;
      valid = (state_q != EMPTY);
      deq   = valid & bus.INSTR_READY;
      enq   = inflight_q & ~br;
      cnt   = state_q;
      occ   = {1'b0, cnt} + {2'b0, inflight_q} - {2'b0, deq};
      issue = br | (occ < 3'd2);
      wr_hi = ((state_q == ONE) & ~deq) | (state_q == FULL);
   end

   // Occupancy FSM register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Occupancy next state; a redirect flushes the buffer
   always_comb begin
      state_d = state_q;
      if (br) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (enq) state_d = ONE;
            ONE: begin
               if (enq & ~deq)      state_d = FULL;
               else if (~enq & deq) state_d = EMPTY;
            end
            FULL: if (deq & ~enq)   state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   // PC, issued address and outstanding-read flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= RESET_PC;
         iss_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else if (br) begin
         pc_q       <= bus.BR_TARGET + 8'd1;
         iss_pc_q   <= bus.BR_TARGET;
         inflight_q <= 1'b1;
      end else if (issue) begin
         pc_q       <= pc_q + 8'd1;
         iss_pc_q   <= pc_q;
         inflight_q <= 1'b1;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   // Buffer storage: pop shifts toward the head, push lands behind it
   always_ff @(posedge CLK) begin
      if (deq) begin
         ent_pc[0]  <= ent_pc[1];
         ent_ins[0] <= ent_ins[1];
      end
      if (enq) begin
         if (wr_hi) begin
            ent_pc[1]  <= iss_pc_q;
            ent_ins[1] <= bus.MEM_RD;
         end else begin
            ent_pc[0]  <= iss_pc_q;
            ent_ins[0] <= bus.MEM_RD;
         end
      end
   end

   // Output drive: read-only memory port and buffer head
   always_comb begin
      bus.MEM_ADDR    = br ? bus.BR_TARGET : pc_q;
      bus.MEM_WD      = 16'h0000;
      bus.MEM_WE      = 1'b0;
      bus.INSTR_VALID = valid;
      bus.INSTR       = valid ? ent_ins[0] : 16'h0000;
      bus.INSTR_PC    = valid ? ent_pc[0]  : 8'h00;
   end

`ifdef FETCH_STALL_CNT_EN
   // Saturating count of cycles with no instruction offered
   always_ff @(posedge CLK) begin
      if (RST)
         STALL_CNT <= 16'h0000;
      else if (!valid && STALL_CNT != 16'hFFFF)
         STALL_CNT <= STALL_CNT + 16'd1;
   end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 8'h00, first instruction address issued after reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 MEM_ADDR  output  8  read address to memory port 0.
REQ-005 MEM_WD  output  16  write data to memory port 0; constant 16'h0000.
REQ-006 MEM_WE  output  1  write enable to memory port 0; constant 0.
REQ-007 MEM_RD  input  16  memory read data; valid in the cycle after MEM_ADDR is sampled (registered-address read).
REQ-008 BR_TAKEN  input  1  redirect request from execute.
REQ-009 BR_TARGET  input  8  redirect address, qualified by BR_TAKEN.
REQ-010 INSTR  output  16  instruction word at buffer head.
REQ-011 INSTR_PC  output  8  address of INSTR.
REQ-012 INSTR_VALID  output  1  buffer head holds a valid instruction.
REQ-013 INSTR_READY  input  1  decode accepts INSTR; transfer when VALID and READY are both 1 at a rising edge.

Function
REQ-014 State: PC reg (8b), INFLIGHT flag (1b), 2-entry FIFO of {pc,instr}, COUNT 0..2; FSM states EMPTY (COUNT=0), ONE (COUNT=1), FULL (COUNT=2).
REQ-015 MEM_ADDR = BR_TAKEN ? BR_TARGET : PC, combinational.
REQ-016 DEQ = INSTR_VALID & INSTR_READY; ISSUE = (COUNT + INFLIGHT - DEQ) < 2.
REQ-017 ISSUE without BR_TAKEN: PC <= PC+1 (mod 256, 8'hFF wraps to 8'h00), INFLIGHT <= 1; no ISSUE: PC held, INFLIGHT <= 0.
REQ-018 INFLIGHT=1 and no BR_TAKEN: {PC of issued read, MEM_RD} enqueued at the edge; issued address tracked internally (8b).
REQ-019 Enqueue and dequeue in the same cycle: COUNT unchanged, FIFO order preserved.
REQ-020 INSTR_VALID = (COUNT != 0), registered; INSTR/INSTR_PC driven from FIFO head; 16'h0000/8'h00 when EMPTY.
REQ-021 FULL: no issue unless DEQ; FIFO never overflows, no instruction dropped or duplicated.
REQ-022 Throughput: with INSTR_READY held 1, one instruction per cycle in steady state, sequential addresses.
REQ-023 Latency: address issued in cycle t appears with INSTR_VALID=1 in cycle t+2.
REQ-024 BR_TAKEN in cycle t: DEQ in cycle t still completes; FIFO cleared, MEM_RD in cycle t discarded, BR_TARGET issued in cycle t, PC <= BR_TARGET+1, INFLIGHT <= 1; next INSTR_VALID=1 in cycle t+2 with INSTR_PC=BR_TARGET.
REQ-025 BR_TAKEN with BR_TARGET=8'hFF: PC <= 8'h00.
REQ-026 BR_TAKEN while FULL or EMPTY: same behaviour as REQ-024.

Reset
REQ-027 RST=1 at an edge: PC <= RESET_PC, INFLIGHT <= 0, COUNT <= 0, FIFO contents don't-care; INSTR_VALID=0 next cycle.
REQ-028 RST has priority over BR_TAKEN and all handshake activity; reset mid-stream discards in-flight and buffered instructions.
REQ-029 First cycle after RST deasserts: MEM_ADDR=RESET_PC; first INSTR_VALID=1 two cycles later.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: extra output STALL_CNT (16b) counts cycles with INSTR_VALID=0; cleared by RST; saturates at 16'hFFFF.
REQ-031 Macro FETCH_STALL_CNT_EN undefined: STALL_CNT port and counter absent; all other behaviour identical.

Verification
REQ-032 Mem preloaded mem[i]=i+16'h1000, RST 2 cycles, READY=1 -> INSTR_VALID rises 2 cycles after release; INSTR/INSTR_PC = 16'h1000/00, 16'h1001/01, ... one per cycle.
REQ-033 READY=0 for 10 cycles after first VALID -> COUNT=2, PC frozen; READY=1 -> PCs 00,01,02,03 delivered, none lost or duplicated.
REQ-034 Stream to PC 8'h05, pulse BR_TAKEN with BR_TARGET=8'h40 -> no INSTR_PC 06/07 accepted after the pulse; INSTR_PC=40 with INSTR=16'h1040 two cycles later.
REQ-035 BR_TARGET=8'hFE, READY=1 -> INSTR_PC sequence FE, FF, 00, 01.
REQ-036 RST asserted mid-stream while FULL, with BR_TAKEN=1 same cycle -> INSTR_VALID=0 next cycle; restart from RESET_PC.
REQ-037 With FETCH_STALL_CNT_EN: reset then READY=1 -> STALL_CNT=2 once streaming; READY toggling does not increment while VALID=1.
